// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one init/done multiplier core with watchdog abort
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_op_a,
  input  logic [16*NREQ-1:0] req_op_b,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [31:0]        resp_result,
  output logic               resp_err,
  output logic               busy,
  output logic               mult_reset,
  output logic               mult_init,
  output logic [15:0]        mult_op_A,
  output logic [15:0]        mult_op_B,
  input  logic [31:0]        mult_result,
  input  logic               mult_done
);
  localparam int CW = $clog2(TIMEOUT + INIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, ABORT} state_t;
  state_t state, nxt;
  logic [IDW-1:0] last, win, id;
  logic [CW-1:0] cnt;
  logic [15:0] sel_a, sel_b;
  logic done_q, rise, grant;
  assign rise = mult_done & ~done_q;
  assign grant = state == IDLE && |req_valid;
  assign busy = state != IDLE;
  assign mult_init = state == LAUNCH;
  assign resp_valid = state == RESP || state == ABORT;
  assign resp_err = state == ABORT;
  assign resp_id = id;
  assign mult_reset = reset | (state == ABORT);
  always_comb begin
    win = '0;
    sel_a = '0;
    sel_b = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (req_valid[k]) win = IDW'(k);
    for (int k = NREQ - 1; k >= 0; k--) if (req_valid[k] && k > int'(last)) win = IDW'(k);
    for (int k = 0; k < NREQ; k++) if (win == IDW'(k)) begin
      sel_a = req_op_a[16*k +: 16];
      sel_b = req_op_b[16*k +: 16];
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = grant ? LAUNCH : IDLE;
      LAUNCH:  nxt = cnt == CW'(INIT_CYCLES - 1) ? WAIT : LAUNCH;
      WAIT:    nxt = rise ? RESP : cnt == CW'(TIMEOUT - 1) ? ABORT : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= IDW'(NREQ - 1);
      id <= '0;
      req_ready <= '0;
      resp_result <= '0;
      mult_op_A <= '0;
      mult_op_B <= '0;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      done_q <= mult_done;
      req_ready <= grant ? NREQ'(1) << win : '0;
      cnt <= nxt != state ? '0 : cnt + CW'(1);
      if (grant) begin
        id <= win;
        last <= win;
        mult_op_A <= sel_a;
        mult_op_B <= sel_b;
      end
      if (nxt == RESP) resp_result <= mult_result;
      else if (nxt == ABORT) resp_result <= '0;
    end
  end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one 16x16->32 sequential multiplier core (init/done handshake) among NREQ requesters, such as CPU MMIO ports and accelerator lanes, on the colorlight femtoriscv SoC.
Arbitration is round-robin. The block latches the winner's operands, drives the core's init, and waits for done. It returns the product tagged with the requester ID.
A watchdog recovers from a hung core by resetting it and returning an error response.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, clog2(NREQ)
INIT_CYCLES, 2, cycles mult_init is held high per launch (>=1)
TIMEOUT, 64, max WAIT cycles before abort (>=4)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous active-high reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  one-cycle accept pulse to the granted requester
req_op_a  in  16*NREQ  packed operand A; requester i at [16i+15:16i]
req_op_b  in  16*NREQ  packed operand B, same packing
resp_valid  out  1  one-cycle response strobe
resp_id  out  IDW  requester index of the response
resp_result  out  32  product (0 on error)
resp_err  out  1  timeout flag, qualified by resp_valid
busy  out  1  high in any state other than IDLE
mult_reset  out  1  core reset
mult_init  out  1  core start
mult_op_A  out  16  latched operand A
mult_op_B  out  16  latched operand B
mult_result  in  32  core product
mult_done  in  1  core completion; level, may stay high between operations

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, busy=0, mult_init=0, mult_op_A/B=0. mult_reset=1 while reset is high. RR pointer last=NREQ-1, so requester 0 has first priority. FSM goes to IDLE.
- Reset mid-operation aborts with no response. Any in-flight request is lost, and its requester must re-request.
- FSM states: IDLE, LAUNCH, WAIT, RESP, ABORT.
- IDLE:
  - If req_valid!=0, grant the first set bit scanning last+1, last+2, ... mod NREQ.
  - On the next edge: req_ready[winner]=1 for exactly 1 cycle, latch op_a/op_b into mult_op_A/B, latch id, last<=winner, go to LAUNCH.
  - If req_valid==0, stay in IDLE.
- Requester contract: hold req_valid and operands stable until req_ready. Dropping req_valid before grant withdraws the request silently. A requester may re-assert in the cycle after req_ready.
- LAUNCH: mult_init=1 for INIT_CYCLES cycles; mult_op_A/B stay stable from grant until RESP. done_q samples mult_done every cycle. Then go to WAIT.
- WAIT:
  - mult_init=0. Completion is the rising edge of mult_done (mult_done & ~done_q). A done level left over from the previous operation is ignored.
  - On completion: capture mult_result into resp_result, go to RESP.
  - The watchdog counts WAIT cycles. When the count reaches TIMEOUT with no rising edge, go to ABORT.
- RESP: resp_valid=1, resp_err=0, resp_id=latched id for 1 cycle, then go to IDLE. resp_result holds its value until the next response.
- ABORT:
  - mult_reset=1 for 1 cycle.
  - In the same cycle: resp_valid=1, resp_err=1, resp_result=0, resp_id=latched id.
  - Go to IDLE.
- Latency: grant edge at T. mult_init is high during T+1..T+INIT_CYCLES. With the done rising edge sampled at cycle D, resp_valid is high at D+1.
- Minimum spacing between grants is INIT_CYCLES+3 cycles. There is no pipelining: one operation is in flight at a time.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Simultaneous events:
  - A new req_valid during RESP/ABORT is first considered in IDLE on the following cycle.
  - mult_done rising in the same cycle the watchdog expires counts as completion, not timeout.
- Arithmetic: no width change. resp_result equals mult_result verbatim (unsigned 16x16).

Test Plan:
- Single request, INIT_CYCLES=2: req0 A=0x0055 B=0x0033 -> req_ready[0] pulses once; mult_init high exactly 2 cycles; resp_valid one cycle after done rise, resp_id=0, resp_result=0x000010EF, resp_err=0.
- All four requesters valid at once with distinct operands (0x0002*0x0003, 0x0004*0x0005, 0xFFFF*0xFFFF, 0x0000*0x1234) -> grants in order 0,1,2,3; results 0x6, 0x14, 0xFFFE0001, 0x0; one operation in flight at a time.
- Round-robin: req1 and req3 held continuously after last=1 -> grant sequence 3,1,3,1; neither starves.
- Stale done: core leaves mult_done high after the previous op -> new op does not complete until done falls and rises again; result is taken from the new op.
- Timeout: core never raises done, TIMEOUT=64 -> after 64 WAIT cycles, mult_reset one cycle, resp_valid with resp_err=1, resp_result=0, correct resp_id; next request then completes normally.
- Reset mid-WAIT: reset asserted for 1 cycle -> no resp_valid, busy=0 next cycle, mult_reset high during reset, next grant goes to requester 0 when multiple requesters are valid.
